// File: rtl/lfsr_offset_search.sv
// Parallel Galois-LFSR offset search: LANES lanes each sweep SEGMENT steps from their own seed
// and report the first offset whose LFSR state equals the captured data word.
module lfsr_offset_search #(
  parameter int unsigned WIDTH    = 17,
  parameter int unsigned LANES    = 4,
  parameter int unsigned SEGMENT  = 29970,
  parameter int unsigned OFFSET_W = 17
) (
  input  logic                clk_96MHz,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    polynomial,
  input  logic [WIDTH-1:0]    data,
  input  logic                start,
  input  logic                abort,
  input  logic                seed_wr,
  input  logic [2:0]          seed_idx,
  input  logic [WIDTH-1:0]    seed_value,
  output logic                ready,
  output logic                valid,
  input  logic                ack,
  output logic [OFFSET_W-1:0] offset,
  output logic                found,
  output logic                timeout
);

  localparam int unsigned CntW = (SEGMENT > 1) ? $clog2(SEGMENT) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e              state_q;
  logic [WIDTH-1:0]    data_q;
  logic [WIDTH-1:0]    poly_q;
  logic [WIDTH-1:0]    lane_q    [LANES];
  logic [WIDTH-1:0]    lane_step [LANES];
  logic [WIDTH-1:0]    seed_q    [LANES];
  logic [CntW-1:0]     cnt_q;
  logic                ready_q;
  logic                valid_q;
  logic                found_q;
  logic                timeout_q;
  logic [OFFSET_W-1:0] offset_q;

  logic                hit;
  logic [OFFSET_W-1:0] hit_off;

  // Scan from the top lane down so the lowest-index match is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_off = '0;
    for (int k = int'(LANES) - 1; k >= 0; k--) begin
      if (lane_q[k] == data_q) begin
        hit     = 1'b1;
        hit_off = OFFSET_W'(cnt_q) + OFFSET_W'(k * SEGMENT);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_step[k] = lane_q[k][0] ? ((lane_q[k] >> 1) ^ poly_q) : (lane_q[k] >> 1);
    end
  end

  // Seed table; entry 0 is unused because lane 0 always starts from 1.
  always_ff @(posedge clk_96MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LANES; k++) seed_q[k] <= '0;
    end else if (state_q == StIdle && seed_wr) begin
      for (int k = 1; k < LANES; k++) begin
        if (seed_idx == 3'(k)) seed_q[k] <= seed_value;
      end
    end
  end

  always_ff @(posedge clk_96MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      data_q    <= '0;
      poly_q    <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      found_q   <= 1'b0;
      timeout_q <= 1'b0;
      offset_q  <= '0;
      for (int k = 0; k < LANES; k++) lane_q[k] <= '0;
    end else if (abort) begin
      state_q   <= StIdle;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      found_q   <= 1'b0;
      timeout_q <= 1'b0;
      offset_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            data_q  <= data;
            poly_q  <= polynomial;
            ready_q <= 1'b0;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          lane_q[0] <= WIDTH'(1);
          for (int k = 1; k < LANES; k++) lane_q[k] <= seed_q[k];
          cnt_q <= '0;
          // An all-zero word is never produced from a nonzero start, so report it at once.
          if (data_q == '0) begin
            valid_q   <= 1'b1;
            found_q   <= 1'b0;
            timeout_q <= 1'b1;
            offset_q  <= '0;
            state_q   <= StDone;
          end else begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (hit) begin
            valid_q   <= 1'b1;
            found_q   <= 1'b1;
            timeout_q <= 1'b0;
            offset_q  <= hit_off;
            state_q   <= StDone;
          end else if (cnt_q == CntW'(SEGMENT - 1)) begin
            valid_q   <= 1'b1;
            found_q   <= 1'b0;
            timeout_q <= 1'b1;
            offset_q  <= '0;
            state_q   <= StDone;
          end else begin
            for (int k = 0; k < LANES; k++) lane_q[k] <= lane_step[k];
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (ack) begin
            valid_q   <= 1'b0;
            found_q   <= 1'b0;
            timeout_q <= 1'b0;
            ready_q   <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready   = ready_q;
  assign valid   = valid_q;
  assign found   = found_q;
  assign timeout = timeout_q;
  assign offset  = offset_q;

endmodule

// File: tb/tb_lfsr_offset_search.sv
// Directed bench for lfsr_offset_search: hand-computed vectors plus a lane-0 LFSR model for the
// long-window cases.
module tb_lfsr_offset_search;

  localparam int unsigned W   = 17;
  localparam int unsigned NL  = 4;
  localparam int unsigned SEG = 29970;
  localparam int unsigned OW  = 17;
  localparam logic [W-1:0] Poly = 17'h1d258;

  logic          clk_96MHz = 1'b0;
  logic          rst_n     = 1'b1;
  logic [W-1:0]  polynomial = '0;
  logic [W-1:0]  data       = '0;
  logic          start      = 1'b0;
  logic          abort      = 1'b0;
  logic          seed_wr    = 1'b0;
  logic [2:0]    seed_idx   = '0;
  logic [W-1:0]  seed_value = '0;
  logic          ack        = 1'b0;
  logic          ready;
  logic          valid;
  logic [OW-1:0] offset;
  logic          found;
  logic          timeout;

  int vecs = 0;
  int errs = 0;

  always #5 clk_96MHz = ~clk_96MHz;

  lfsr_offset_search #(
    .WIDTH    (W),
    .LANES    (NL),
    .SEGMENT  (SEG),
    .OFFSET_W (OW)
  ) dut (
    .clk_96MHz  (clk_96MHz),
    .rst_n      (rst_n),
    .polynomial (polynomial),
    .data       (data),
    .start      (start),
    .abort      (abort),
    .seed_wr    (seed_wr),
    .seed_idx   (seed_idx),
    .seed_value (seed_value),
    .ready      (ready),
    .valid      (valid),
    .ack        (ack),
    .offset     (offset),
    .found      (found),
    .timeout    (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] lstep(input logic [W-1:0] v, input logic [W-1:0] p);
    return v[0] ? ((v >> 1) ^ p) : (v >> 1);
  endfunction

  // Position of d in lane 0's window (starting from 1), or -1 when it is not reached.
  function automatic int lane0_hit(input logic [W-1:0] d, input logic [W-1:0] p);
    logic [W-1:0] v;
    int           m;
    v = W'(1);
    m = -1;
    for (int i = 0; i < int'(SEG); i++) begin
      if (m < 0 && v == d) m = i;
      v = lstep(v, p);
    end
    return m;
  endfunction

  task automatic tick();
    @(posedge clk_96MHz);
    #1;
  endtask

  task automatic run_search(input string tag, input logic [W-1:0] d, input logic [W-1:0] p,
                            input logic scramble, input logic ef, input logic et,
                            input int eoff, input int elat);
    int lat;
    data       = d;
    polynomial = p;
    start      = 1'b1;
    tick();
    start = 1'b0;
    if (scramble) begin
      data       = W'(1);
      polynomial = '0;
    end
    chk({tag, ".ready_low"}, 32'(ready), 32'd0);
    lat = 0;
    while (!valid && lat < int'(SEG) + 8) begin
      tick();
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(elat));
    chk({tag, ".found"}, 32'(found), 32'(ef));
    chk({tag, ".timeout"}, 32'(timeout), 32'(et));
    chk({tag, ".offset"}, 32'(offset), 32'(eoff));
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk({tag, ".ack_valid"}, 32'(valid), 32'd0);
    chk({tag, ".ack_found"}, 32'(found), 32'd0);
    chk({tag, ".ack_timeout"}, 32'(timeout), 32'd0);
    chk({tag, ".ack_ready"}, 32'(ready), 32'd1);
  endtask

  task automatic write_seed(input logic [2:0] idx, input logic [W-1:0] val);
    seed_wr    = 1'b1;
    seed_idx   = idx;
    seed_value = val;
    tick();
    seed_wr = 1'b0;
  endtask

  initial begin
    logic [W-1:0] far;
    int           m;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst.ready", 32'(ready), 32'd1);
    chk("rst.valid", 32'(valid), 32'd0);
    chk("rst.found", 32'(found), 32'd0);
    chk("rst.timeout", 32'(timeout), 32'd0);
    chk("rst.offset", 32'(offset), 32'd0);
    repeat (3) @(posedge clk_96MHz);
    #1 rst_n = 1'b1;

    // Lane 0 matches at counter 0
    run_search("d1", 17'h00001, Poly, 1'b0, 1'b1, 1'b0, 0, 2);
    // start and a seed write while DONE are both ignored
    data       = '0;
    start      = 1'b1;
    seed_wr    = 1'b1;
    seed_idx   = 3'd1;
    seed_value = 17'h1f555;
    tick();
    start   = 1'b0;
    seed_wr = 1'b0;
    chk("d1.hold_valid", 32'(valid), 32'd1);
    chk("d1.hold_found", 32'(found), 32'd1);
    chk("d1.hold_timeout", 32'(timeout), 32'd0);
    do_ack("d1");

    // Zero data reports timeout straight from LOAD
    run_search("d0", 17'h00000, Poly, 1'b0, 1'b0, 1'b1, 0, 1);
    do_ack("d0");

    // Out-of-range seed indices are ignored, then lane 2 is seeded
    write_seed(3'd0, 17'h1f555);
    write_seed(3'd5, 17'h1f555);
    write_seed(3'd7, 17'h1f555);
    write_seed(3'd2, 17'h1f555);
    run_search("seed2", 17'h1f555, Poly, 1'b0, 1'b1, 1'b0, 59940, 2);

    // Reset while DONE drops valid at once and clears the seed table
    #2 rst_n = 1'b0;
    #1;
    chk("rstdone.valid", 32'(valid), 32'd0);
    chk("rstdone.ready", 32'(ready), 32'd1);
    chk("rstdone.found", 32'(found), 32'd0);
    @(posedge clk_96MHz);
    #1 rst_n = 1'b1;
    m = lane0_hit(17'h1f555, Poly);
    if (m >= 0) run_search("noseed", 17'h1f555, Poly, 1'b0, 1'b1, 1'b0, m, 2 + m);
    else        run_search("noseed", 17'h1f555, Poly, 1'b0, 1'b0, 1'b1, 0, 1 + int'(SEG));
    do_ack("noseed");

    // Target: lane-0 state after 4*SEGMENT steps
    far = W'(1);
    for (int i = 0; i < 4 * int'(SEG); i++) far = lstep(far, Poly);
    m = lane0_hit(far, Poly);

    // Abort 100 cycles into RUN
    data       = far;
    polynomial = Poly;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (101) tick();
    chk("abort.pre_ready", 32'(ready), 32'd0);
    chk("abort.pre_valid", 32'(valid), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort.ready", 32'(ready), 32'd1);
    chk("abort.valid", 32'(valid), 32'd0);
    repeat (3) tick();
    chk("abort.valid_later", 32'(valid), 32'd0);
    // abort beats a simultaneous start
    data  = 17'h00001;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort.start_ready", 32'(ready), 32'd1);
    run_search("postabort", 17'h00001, Poly, 1'b0, 1'b1, 1'b0, 0, 2);
    do_ack("postabort");

    // Full-window search; inputs change after capture and must not matter
    if (m >= 0) run_search("far", far, Poly, 1'b1, 1'b1, 1'b0, m, 2 + m);
    else        run_search("far", far, Poly, 1'b1, 1'b0, 1'b1, 0, 1 + int'(SEG));
    do_ack("far");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
